flow_ctrl_unit: RTL and testbench

//  Program-flow back end that consumes ALU flag results and executes the flow-class ops.
//  Ops: NOP, jumps, status-register load/XOR, trap. Owns the PC, status register (SR),

---
 rtl/flow_ctrl_unit.sv | 144 ++++++++++++++
 tb/tb_flow_ctrl_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/flow_ctrl_unit.sv
// flow_ctrl_unit: program-flow back end. Owns PC, status register {M,C,S,Z},
// trap save state (epc/saved_sr) and the word-mode bit driven to the ALU.
// Optional build macro FCU_CARRY_TRAP_EN: a valid carry flag in RUN forces a
// trap ahead of any offered op.
module flow_ctrl_unit #(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 20'h00010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_target,
    input  logic [3:0]        op_imm,
    input  logic              flag_valid,
    input  logic              flag_zero,
    input  logic              flag_sign,
    input  logic              flag_carry,
    input  logic              trap_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_load,
    output logic [3:0]        sr,
    output logic              mode,
    output logic              trap_active
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JZ   = 3'd2,
        OP_JS   = 3'd3,
        OP_JZS  = 3'd4,
        OP_LSR  = 3'd5,
        OP_XSR  = 3'd6,
        OP_TRAP = 3'd7
    } op_e;

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] epc, epc_nxt, pc_nxt, seq_pc, jmp_tgt;
    logic [3:0]        saved_sr, saved_sr_nxt, sr_nxt;
    logic              pc_load_nxt, carry_trap, accept, taken;
    logic [9:0]        pc_lo_inc;

`ifdef FCU_CARRY_TRAP_EN
    assign carry_trap = (state == RUN) && flag_valid && flag_carry;
`else
    assign carry_trap = 1'b0;
`endif

    // Half-word mode keeps the PC and jump targets inside the low 1K window.
    assign pc_lo_inc = pc[9:0] + 10'd1;
    assign seq_pc    = sr[3] ? pc + ADDR_W'(1) : {{(ADDR_W-10){1'b0}}, pc_lo_inc};
    assign jmp_tgt   = sr[3] ? op_target : {{(ADDR_W-10){1'b0}}, op_target[9:0]};

    assign op_ready    = (state == RUN) && !rst && !carry_trap;
    assign accept      = op_valid && op_ready;
    assign mode        = sr[3];
    assign trap_active = (state == TRAP);

    // State register and architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc       <= '0;
            sr       <= 4'b1000;
            epc      <= '0;
            saved_sr <= 4'b0000;
            pc_load  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            sr       <= sr_nxt;
            epc      <= epc_nxt;
            saved_sr <= saved_sr_nxt;
            pc_load  <= pc_load_nxt;
        end
    end

    // Next-state and datapath decode; conditions use the SR held before this edge.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        sr_nxt       = sr;
        epc_nxt      = epc;
        saved_sr_nxt = saved_sr;
        pc_load_nxt  = 1'b0;
        taken        = 1'b0;
        // Flags land in any state; LSR/XSR and trap return override below.
        if (flag_valid) sr_nxt[2:0] = {flag_carry, flag_sign, flag_zero};
        case (state)
            RUN: begin
                if (carry_trap) begin
                    epc_nxt      = pc;
                    saved_sr_nxt = sr | 4'b0100;
                    sr_nxt[3]    = 1'b1;
                    pc_nxt       = TRAP_VECTOR;
                    pc_load_nxt  = 1'b1;
                    state_nxt    = TRAP;
                end else if (accept) begin
                    case (op_e'(op_code))
                        OP_JMP:  taken = 1'b1;
                        OP_JZ:   taken = sr[0];
                        OP_JS:   taken = sr[1];
                        OP_JZS:  taken = sr[0] | sr[1];
                        default: taken = 1'b0;
                    endcase
                    pc_nxt = seq_pc;
                    case (op_e'(op_code))
                        OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
                            if (taken) begin
                                pc_nxt      = jmp_tgt;
                                pc_load_nxt = 1'b1;
                            end
                        end
                        OP_LSR: sr_nxt = op_imm;
                        OP_XSR: sr_nxt = sr ^ op_imm;
                        OP_TRAP: begin
                            epc_nxt      = seq_pc;
                            saved_sr_nxt = sr;
                            sr_nxt[3]    = 1'b1;
                            pc_nxt       = TRAP_VECTOR;
                            pc_load_nxt  = 1'b1;
                            state_nxt    = TRAP;
                        end
                        default: ;
                    endcase
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    pc_nxt      = epc;
                    sr_nxt      = saved_sr;
                    pc_load_nxt = 1'b1;
                    state_nxt   = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Directed bench for flow_ctrl_unit with hand-computed expectations.
module tb_flow_ctrl_unit;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid, op_ready;
    logic [2:0]        op_code;
    logic [ADDR_W-1:0] op_target;
    logic [3:0]        op_imm;
    logic              flag_valid, flag_zero, flag_sign, flag_carry;
    logic              trap_ack;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic [3:0]        sr;
    logic              mode, trap_active;

    int n_tests = 0;
    int n_fail  = 0;

    flow_ctrl_unit #(.ADDR_W(ADDR_W), .TRAP_VECTOR(20'h00010)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_target(op_target), .op_imm(op_imm),
        .flag_valid(flag_valid), .flag_zero(flag_zero), .flag_sign(flag_sign),
        .flag_carry(flag_carry), .trap_ack(trap_ack),
        .pc(pc), .pc_load(pc_load), .sr(sr), .mode(mode), .trap_active(trap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_valid = 0; op_code = 0; op_target = '0; op_imm = 0;
        flag_valid = 0; flag_zero = 0; flag_sign = 0; flag_carry = 0;
        trap_ack = 0;
    endtask

    task automatic do_op(input logic [2:0] c, input logic [ADDR_W-1:0] t, input logic [3:0] i);
        op_valid = 1; op_code = c; op_target = t; op_imm = i;
        tick();
        idle();
    endtask

    task automatic do_flags(input logic z, input logic s, input logic c);
        flag_valid = 1; flag_zero = z; flag_sign = s; flag_carry = c;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        #2;
        chk("ready_in_reset", op_ready, 0);
        tick(); tick();
        rst = 0;
        #1;
        // 1 reset state
        chk("rst_pc", pc, 0);
        chk("rst_sr", sr, 4'b1000);
        chk("rst_ready", op_ready, 1);
        chk("rst_trap", trap_active, 0);
        chk("rst_pcload", pc_load, 0);
        chk("rst_mode", mode, 1);

        // 2 conditional jumps
        do_flags(1, 0, 0);
        chk("flag_z_sr", sr, 4'b1001);
        do_op(3'd2, 20'h12345, 0);
        chk("jz_taken_pc", pc, 20'h12345);
        chk("jz_taken_load", pc_load, 1);
        tick();
        chk("load_pulse_end", pc_load, 0);
        chk("idle_pc_hold", pc, 20'h12345);
        do_flags(0, 0, 0);
        do_op(3'd2, 20'h12345, 0);
        chk("jz_not_pc", pc, 20'h12346);
        chk("jz_not_load", pc_load, 0);
        do_flags(0, 1, 0);
        do_op(3'd3, 20'h00400, 0);
        chk("js_taken_pc", pc, 20'h00400);
        do_op(3'd4, 20'h00500, 0);
        chk("jzs_taken_pc", pc, 20'h00500);

        // 3 half-word wrap and target masking
        do_op(3'd1, 20'h003FE, 0);
        do_op(3'd5, 0, 4'b0000);
        chk("lsr_pc", pc, 20'h003FF);
        chk("lsr_mode", mode, 0);
        do_op(3'd0, 0, 0);
        chk("half_wrap", pc, 20'h00000);
        do_op(3'd1, 20'hABCDE, 0);
        chk("half_jmp", pc, 20'h000DE);

        // 4 trap entry / return
        do_op(3'd5, 0, 4'b1000);
        do_op(3'd1, 20'h000FF, 0);
        do_op(3'd5, 0, 4'b0101);
        chk("pre_trap_pc", pc, 20'h00100);
        chk("pre_trap_sr", sr, 4'b0101);
        do_op(3'd7, 0, 0);
        chk("trap_pc", pc, 20'h00010);
        chk("trap_sr", sr, 4'b1101);
        chk("trap_active", trap_active, 1);
        chk("trap_ready", op_ready, 0);
        chk("trap_load", pc_load, 1);
        do_op(3'd1, 20'h00777, 0);
        chk("trap_blocks_op", pc, 20'h00010);
        trap_ack = 1; tick(); idle();
        chk("ret_pc", pc, 20'h00101);
        chk("ret_sr", sr, 4'b0101);
        chk("ret_active", trap_active, 0);
        chk("ret_load", pc_load, 1);
        trap_ack = 1; tick(); idle();
        chk("ack_in_run_pc", pc, 20'h00101);
        chk("ack_in_run_load", pc_load, 0);

        // 5 XSR wins over same-edge flags
        do_op(3'd5, 0, 4'b1000);
        chk("lsr_half_pc", pc, 20'h00102);
        flag_valid = 1; flag_zero = 1; flag_carry = 1;
        do_op(3'd6, 0, 4'b0001);
        chk("xsr_sr", sr, 4'b1001);
        chk("xsr_pc", pc, 20'h00103);

        // 6 carry flag with a competing op
        do_op(3'd1, 20'h00050, 0);
        chk("pre_carry_pc", pc, 20'h00050);
        flag_valid = 1; flag_carry = 1;
        op_valid = 1; op_code = 3'd1; op_target = 20'h00200;
        #1;
`ifdef FCU_CARRY_TRAP_EN
        chk("ctrap_ready", op_ready, 0);
        tick(); idle();
        chk("ctrap_pc", pc, 20'h00010);
        chk("ctrap_active", trap_active, 1);
        trap_ack = 1; tick(); idle();
        chk("ctrap_ret_pc", pc, 20'h00050);
        chk("ctrap_ret_c", sr[2], 1);
`else
        chk("carry_ready", op_ready, 1);
        tick(); idle();
        chk("carry_jmp_pc", pc, 20'h00200);
        chk("carry_sr", sr, 4'b1100);
        chk("carry_no_trap", trap_active, 0);
`endif

        // 7 reset mid-trap drops saved context
        do_op(3'd7, 0, 0);
        chk("mid_trap_active", trap_active, 1);
        rst = 1;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_sr", sr, 4'b1000);
        chk("mid_rst_active", trap_active, 0);
        chk("mid_rst_ready", op_ready, 0);
        tick();
        rst = 0;
        trap_ack = 1; tick(); idle();
        chk("post_rst_ack_pc", pc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
